// File: rtl/pulse_receiver.sv
// Pulse-width receiver: measures how long a synchronized line holds each level
// and queues {level, duration} records in a small FIFO for the host to pop.
module pulse_receiver #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          idle_level,
  input  logic [7:0]                    prescale,
  input  logic [CNT_W-1:0]              timeout,
  input  logic                          sig_in,
  input  logic                          rd_en,
  output logic [CNT_W:0]                rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          busy
);

  localparam int unsigned REC_W  = CNT_W + 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTF_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DUR_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sig_s, sig_d;
  logic [7:0]         presc_q, presc_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic               cur_level_q, cur_level_d;

  logic               edge_c;
  logic               wrap_c;
  logic [7:0]         presc_tick_c;
  logic [CNT_W-1:0]   dur_tick_c;
  logic               push_c;
  logic [REC_W-1:0]   push_rec_c;

  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTF_W-1:0]  count_q;
  logic               overflow_q;
  logic               pop_c, full_c, do_push_c, drop_c;

  // Two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sig_s   <= 1'b0;
      sig_d   <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sig_s   <= sync1_q;
      sig_d   <= sig_s;
    end
  end

  // Every MEASURE cycle counts toward the level still visible on sig_d, so the
  // edge cycle closes the old level and the new level starts from zero.
  assign edge_c       = sig_s ^ sig_d;
  assign wrap_c       = (presc_q >= prescale);
  assign presc_tick_c = wrap_c ? 8'd0 : presc_q + 8'd1;
  assign dur_tick_c   = (wrap_c && (dur_q != DUR_MAX)) ? dur_q + CNT_W'(1) : dur_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= 8'd0;
      dur_q       <= '0;
      cur_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      dur_q       <= dur_d;
      cur_level_q <= cur_level_d;
    end
  end

  // Next-state and record generation; an edge outranks a timeout
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    dur_d       = dur_q;
    cur_level_d = cur_level_q;
    push_c      = 1'b0;
    push_rec_c  = '0;
    case (state_q)
      IDLE: begin
        if (en && (sig_s != idle_level)) begin
          state_d     = MEASURE;
          presc_d     = 8'd0;
          dur_d       = '0;
          cur_level_d = sig_s;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
          presc_d = 8'd0;
          dur_d   = '0;
        end else if (edge_c) begin
          push_c      = 1'b1;
          push_rec_c  = {cur_level_q, dur_tick_c};
          presc_d     = 8'd0;
          dur_d       = '0;
          cur_level_d = ~cur_level_q;
        end else if ((timeout != '0) && (cur_level_q == idle_level) &&
                     (dur_tick_c >= timeout)) begin
          push_c     = 1'b1;
          push_rec_c = {idle_level, timeout};
          state_d    = IDLE;
          presc_d    = 8'd0;
          dur_d      = '0;
        end else begin
          presc_d = presc_tick_c;
          dur_d   = dur_tick_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Record FIFO: a pop frees room for a same-cycle push even when full
  assign pop_c     = rd_en && (count_q != '0);
  assign full_c    = (count_q == CNTF_W'(FIFO_DEPTH));
  assign do_push_c = push_c && (!full_c || pop_c);
  assign drop_c    = push_c && full_c && !pop_c;

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr_q] <= push_rec_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_c, pop_c})
        2'b10:   count_q <= count_q + CNTF_W'(1);
        2'b01:   count_q <= count_q - CNTF_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == MEASURE);

endmodule

// File: doc/pulse_receiver.md
PULSE_RECEIVER -- requirements
Module: pulse_receiver

Interface
REQ-001 Parameter CNT_W, default 12: width of a measured duration.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two: record FIFO depth.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  receiver enable.
REQ-006 idle_level  input  1  line level when no pulse is present.
REQ-007 prescale  input  8  tick period is prescale+1 clocks.
REQ-008 timeout  input  CNT_W  idle-level duration, in ticks, that ends a frame; 0 disables timeout.
REQ-009 sig_in  input  1  asynchronous pulse line.
REQ-010 rd_en  input  1  pop the FIFO head.
REQ-011 rd_data  output  CNT_W+1  head record {level, duration}, MSB is level.
REQ-012 rd_valid  output  1  FIFO not empty.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  records held.
REQ-014 overflow  output  1  sticky: a record was dropped.
REQ-015 overflow_clr  input  1  clears overflow.
REQ-016 busy  output  1  high in MEASURE.

Function
REQ-017 sig_in SHALL pass through a 2-flop synchronizer (sig_s); edges SHALL be detected by comparing sig_s with a 1-cycle delayed copy.
REQ-018 The FSM SHALL have two states, IDLE and MEASURE.
REQ-019 IDLE: on the first cycle sig_s != idle_level with en=1, go to MEASURE, clear prescaler and duration counter, set cur_level = sig_s.
REQ-020 MEASURE: the prescaler counts 0..prescale; on wrap, duration increments, saturating at 2^CNT_W-1.
REQ-021 Recorded duration SHALL equal floor(N/(prescale+1)), where N is the number of clocks sig_s held cur_level, saturated.
REQ-022 On a sig_s edge in MEASURE: push {cur_level, duration}, restart prescaler and counter for the new level, toggle cur_level, in the same cycle.
REQ-023 With timeout != 0 and cur_level == idle_level, when duration reaches timeout: push {idle_level, timeout} and return to IDLE.
REQ-024 A timeout and an edge in the same cycle: the edge takes priority and the FSM stays in MEASURE.
REQ-025 en=0 SHALL force IDLE the next cycle and discard the partial measurement; FIFO contents and overflow are retained.
REQ-026 FIFO: rd_data SHALL show the head combinationally; rd_en with rd_valid=1 pops; rd_en with rd_valid=0 is ignored.
REQ-027 A push when full with no pop SHALL drop the new record and set overflow.
REQ-028 A push and pop in the same cycle when full SHALL both take effect, with no overflow.
REQ-029 overflow_clr SHALL clear overflow; a simultaneous overflow event SHALL win (overflow stays 1).
REQ-030 The pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
REQ-031 prescale and timeout SHALL be sampled live; changing them mid-pulse affects only the remaining ticks.

Reset
REQ-032 While rst=1: FSM=IDLE, synchronizer and delay flops = 0, counters = 0, FIFO empty, rd_valid=0, fifo_count=0, overflow=0, busy=0, rd_data=0.
REQ-033 Reset assertion mid-measurement SHALL abort immediately with no record pushed.
REQ-034 After reset release, a line already at !idle_level SHALL start MEASURE once it propagates through the synchronizer.

Verification
REQ-035 prescale=0, idle_level=0, timeout=20: sig_in high 5 clk, then low -> records {1,5} then {0,20}, FSM back in IDLE, fifo_count=2.
REQ-036 prescale=3, idle_level=0, timeout=0: high 16 clk, low 10 clk, high 7 clk -> records {1,4}, {0,2}; on 4th edge {1,1}; busy stays 1.
REQ-037 CNT_W=4, prescale=0: high 40 clk -> record {1,15} (saturated).
REQ-038 Four records held, fifth pushed without rd_en -> fifth dropped, overflow=1, head unchanged; repeat with rd_en in the push cycle -> no overflow, fifo_count stays 4.
REQ-039 en dropped mid-pulse, then re-enabled while the line is idle -> no record pushed, FSM IDLE; the next pulse measures correctly.
REQ-040 rst pulsed during MEASURE with 2 records queued -> all outputs at reset values immediately, no further pushes.
